// File: rtl/cic_decim.sv
// N-stage CIC decimator (M=1) feeding off the DDC mixer product, one per I/Q branch.
// Define CIC_ROUND_EN for round-half-up output scaling; default build truncates.
module cic_decim #(
  parameter int N_STAGES   = 3,
  parameter int DEC_RATE   = 16,
  parameter int DIN_WIDTH  = 16,
  parameter int DOUT_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         en_i,
  input  logic signed [DIN_WIDTH-1:0]  data_i,
  output logic signed [DOUT_WIDTH-1:0] data_o,
  output logic                         valid_o
);

  localparam int CNT_W = $clog2(DEC_RATE);
  localparam int RW    = DIN_WIDTH + N_STAGES * CNT_W;
  localparam int RSH   = (RW > DOUT_WIDTH) ? RW - DOUT_WIDTH - 1 : 0;
  localparam logic [RW-1:0] ONE = {{(RW-1){1'b0}}, 1'b1};
  localparam logic [RW-1:0] RND = (RW > DOUT_WIDTH) ? ONE << RSH : '0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEC_RATE - 1);

  logic signed [RW-1:0] integ [N_STAGES];
  logic signed [RW-1:0] comb  [N_STAGES];
  logic signed [RW-1:0] dly   [N_STAGES];
  logic signed [RW-1:0] cin   [N_STAGES];
  logic signed [RW-1:0] samp;
  logic signed [RW-1:0] din_ext;
  logic signed [RW-1:0] c_fin;
  logic [CNT_W-1:0]     cnt;
  logic [N_STAGES+1:0]  stb;
  logic                 dec;

  assign din_ext = {{(RW-DIN_WIDTH){data_i[DIN_WIDTH-1]}}, data_i};
  assign dec     = en_i && (cnt == CNT_LAST);

  always_comb begin
    cin[0] = samp;
    for (int k = 1; k < N_STAGES; k++) begin
      cin[k] = comb[k-1];
    end
  end

`ifdef CIC_ROUND_EN
  assign c_fin = comb[N_STAGES-1] + RND;
`else
  assign c_fin = comb[N_STAGES-1];
  logic unused_rnd;
  assign unused_rnd = ^RND;
`endif

  // Integrators wrap freely; the combs undo the wrap modulo 2^RW.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < N_STAGES; k++) begin
        integ[k] <= '0;
        comb[k]  <= '0;
        dly[k]   <= '0;
      end
      samp    <= '0;
      cnt     <= '0;
      stb     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      if (en_i) begin
        integ[0] <= integ[0] + din_ext;
        for (int k = 1; k < N_STAGES; k++) begin
          integ[k] <= integ[k] + integ[k-1];
        end
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      end
      stb <= {stb[N_STAGES:0], dec};
      if (stb[0]) begin
        samp <= integ[N_STAGES-1];
      end
      for (int k = 0; k < N_STAGES; k++) begin
        if (stb[k+1]) begin
          comb[k] <= cin[k] - dly[k];
          dly[k]  <= cin[k];
        end
      end
      valid_o <= stb[N_STAGES+1];
      if (stb[N_STAGES+1]) begin
        data_o <= c_fin[RW-1 -: DOUT_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_cic_decim.sv
// Directed bench for cic_decim: impulse-response golden model feeding
// a scoreboard of expected samples and valid_o cycle positions.
module tb_cic_decim;

  localparam int N  = 3;
  localparam int R  = 16;
  localparam int LAT = N + 2;
  localparam int LG = N * (R - 1) + 1 + (N - 1);

  logic               clk;
  logic               rst_n;
  logic               en;
  logic signed [15:0] din;
  logic signed [15:0] dout;
  logic               vld;

  typedef struct {
    logic signed [15:0] d;
    int                 c;
  } exp_t;

  exp_t    sb[$];
  longint  xs[$];
  longint  g[LG];
  int      cyc;
  int      total;
  int      passed;

  cic_decim #(
    .N_STAGES(N), .DEC_RATE(R),
    .DIN_WIDTH(16), .DOUT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .data_i(din), .data_o(dout), .valid_o(vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  // Golden output: convolve accepted samples with the CIC impulse response.
  function automatic longint model_out();
    longint y;
    int     n;
    y = 0;
    n = xs.size();
    for (int j = 0; j < LG; j++) begin
      if (n - 1 - j >= 0) y += g[j] * xs[n-1-j];
    end
`ifdef CIC_ROUND_EN
    y += 2048;
`endif
    return y >>> 12;
  endfunction

  task automatic drive(input logic e, input logic signed [15:0] d);
    exp_t x;
    @(posedge clk);
    #1;
    en  = e;
    din = d;
    if (e && rst_n) begin
      xs.push_back(longint'(d));
      if (xs.size() % R == 0) begin
        x.d = 16'(model_out());
        x.c = cyc + 1 + LAT;
        sb.push_back(x);
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    @(posedge clk);
    #1;
    en = 1'b0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en    = 1'b1;
    din   = 16'sd77;
    xs.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b0;
    din   = '0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (vld) begin
      chk("valid_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data_o", dout, e.d);
        chk("latency", cyc, e.c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint p[LG];
    longint q[LG];
    total  = 0;
    passed = 0;
    for (int i = 0; i < LG; i++) p[i] = 0;
    p[0] = 1;
    repeat (N) begin
      for (int i = 0; i < LG; i++) q[i] = 0;
      for (int i = 0; i < LG; i++)
        for (int j = 0; j < R; j++)
          if (i + j < LG) q[i+j] += p[i];
      p = q;
    end
    for (int j = 0; j < LG; j++)
      g[j] = (j >= N - 1) ? p[j-(N-1)] : 0;

    rst_n = 1'b0;
    en    = 1'b1;
    din   = 16'sd123;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_o", dout, 0);
    chk("rst_valid_o", vld, 0);
    rst_n = 1'b1;
    en    = 1'b0;

    // DC step
    repeat (6 * R) drive(1'b1, 16'sd5);
    drain();
    chk("dc_hold", dout, 5);

    // Full scale both signs, integrators wrap
    repeat (5 * R) drive(1'b1, -16'sd32768);
    drain();
    chk("fs_neg_hold", dout, -32768);
    repeat (5 * R) drive(1'b1, 16'sd32767);
    drain();
    chk("fs_pos_hold", dout, 32767);

    // Throttled enable, 1 in 3
    repeat (4 * R) begin
      drive(1'b1, 16'sd1000);
      drive(1'b0, 16'sd1000);
      drive(1'b0, -16'sd9);
    end
    drain();
    chk("thr_hold", dout, 1000);

    // Mid-operation reset
    repeat (7) drive(1'b1, 16'sd5);
    pulse_reset();
    chk("midrst_data_o", dout, 0);
    chk("midrst_valid_o", vld, 0);
    repeat (4 * R) drive(1'b1, 16'sd5);
    drain();

    // Impulse response
    pulse_reset();
    drive(1'b1, 16'sd4096);
    repeat (6 * R - 1) drive(1'b1, 16'sd0);
    drain();

    chk("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
